// File: rtl/condlogic_flagreg.sv
// ----------------------------------------------------------------------------
// condlogic_flagreg
//   Producer side of the condition-flag interface for the multicycle ARM core.
//   Holds the architectural NZCV register and drives it to the condition
//   checker. Captures the checker's result (CondEx) at the end of decode and
//   uses that registered result to qualify the flag update and the PC,
//   register-file and memory write strobes requested by the main FSM.
//
// Parameters
//   FLAG_RESET          NZCV value loaded on reset, ordered {N,Z,C,V}
//
// Ports
//   i_clk               rising-edge clock
//   i_reset             asynchronous, active-high reset
//   i_alu_flags[3:0]    {N,Z,C,V} from the ALU for the current execute cycle
//   i_flag_w[1:0]       [1]: request N,Z update; [0]: request C,V update
//   i_cond_ex_in        condition result from the checker (evaluated on o_flags)
//   i_cond_ex_latch     capture i_cond_ex_in on this edge (end of decode)
//   i_pcs               instruction writes the PC
//   i_next_pc           unconditional PC update (fetch)
//   i_reg_w             register-file write request
//   i_mem_w             memory write request
//   o_flags[3:0]        registered NZCV
//   o_cond_ex_delayed   registered condition result for the current instruction
//   o_pc_write          qualified PC write enable (combinational)
//   o_reg_write         qualified register-file write enable (combinational)
//   o_mem_write         qualified memory write enable (combinational)
// ----------------------------------------------------------------------------
module condlogic_flagreg #(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,
   input  logic       i_cond_ex_in,
   input  logic       i_cond_ex_latch,
   input  logic       i_pcs,
   input  logic       i_next_pc,
   input  logic       i_reg_w,
   input  logic       i_mem_w,
   output logic [3:0] o_flags,
   output logic       o_cond_ex_delayed,
   output logic       o_pc_write,
   output logic       o_reg_write,
   output logic       o_mem_write
);

   logic [3:0] r_flags;
   logic       r_cond_ex_delayed;
   logic       w_wr_nz;
   logic       w_wr_cv;

   // Flag halves are qualified by the condition captured at decode, so a
   // same-cycle latch never affects the flag write of that cycle.
   assign w_wr_nz = i_flag_w[1] & r_cond_ex_delayed;
   assign w_wr_cv = i_flag_w[0] & r_cond_ex_delayed;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cond_ex_delayed <= 1'b0;
      end else if (i_cond_ex_latch) begin
         r_cond_ex_delayed <= i_cond_ex_in;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_flags[3:2] <= FLAG_RESET[3:2];
      end else if (w_wr_nz) begin
         r_flags[3:2] <= i_alu_flags[3:2];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_flags[1:0] <= FLAG_RESET[1:0];
      end else if (w_wr_cv) begin
         r_flags[1:0] <= i_alu_flags[1:0];
      end
   end

   always_comb begin
      o_pc_write  = (i_pcs & r_cond_ex_delayed) | i_next_pc;
      o_reg_write = i_reg_w & r_cond_ex_delayed;
      o_mem_write = i_mem_w & r_cond_ex_delayed;
   end

   assign o_flags           = r_flags;
   assign o_cond_ex_delayed = r_cond_ex_delayed;

endmodule
